// File: rtl/range_byte_assembler_if.sv
// Byte-stream framing bus between the sample feeder and range_byte_assembler.
// The master drives bytes and frame markers; the slave returns words and range-finder controls.
interface range_byte_assembler_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               frame_start;
  logic               frame_end;
  logic [WIDTH-1:0]   data_out;
  logic               go;
  logic               finish;
  logic [COUNT_W-1:0] word_count;
  logic               frame_error;
  logic               busy;

  modport master (
    output byte_in, byte_valid, frame_start, frame_end,
    input  data_out, go, finish, word_count, frame_error, busy
  );

  modport slave (
    input  byte_in, byte_valid, frame_start, frame_end,
    output data_out, go, finish, word_count, frame_error, busy
  );
endinterface

// File: rtl/range_byte_assembler.sv
// Frames byte samples into WIDTH-bit words (MSB byte first) and sequences go/finish
// so that each frame produces exactly one downstream range result.
module range_byte_assembler #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  range_byte_assembler_if.slave  bus
);
  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, FINISH, ERROR} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   shift_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               sent_q;
  logic               go_q;
  logic               finish_q;
  logic               err_q;
  logic               busy_q;

  logic               fresh_d;
  logic               absorb_d;
  logic               complete_d;
  logic               sent_base_d;
  logic               sent_d;
  logic [IDX_W-1:0]   idx_base_d;
  logic [IDX_W-1:0]   idx_d;
  logic [COUNT_W-1:0] cnt_base_d;
  logic [COUNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]   shift_d;

  // A frame_start out of IDLE/ERROR absorbs its byte against a cleared context.
  always_comb begin
    fresh_d     = ((state_q == IDLE) || (state_q == ERROR)) && bus.frame_start;
    absorb_d    = fresh_d || (state_q == COLLECT);
    idx_base_d  = fresh_d ? '0 : idx_q;
    cnt_base_d  = fresh_d ? '0 : cnt_q;
    sent_base_d = fresh_d ? 1'b0 : sent_q;
    complete_d  = bus.byte_valid && (idx_base_d == IDX_W'(BYTES - 1));
    shift_d     = (shift_q << 8) | WIDTH'(bus.byte_in);

    idx_d = idx_base_d;
    if (bus.byte_valid) begin
      idx_d = complete_d ? '0 : idx_base_d + IDX_W'(1);
    end

    cnt_d = cnt_base_d;
    if (complete_d && !(&cnt_base_d)) begin
      cnt_d = cnt_base_d + COUNT_W'(1);
    end

    sent_d = sent_base_d | complete_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      sent_q   <= 1'b0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      go_q     <= 1'b0;
      finish_q <= 1'b0;

      if (absorb_d) begin
        if (bus.byte_valid) begin
          shift_q <= shift_d;
        end
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
        sent_q <= sent_d;
        if (complete_d) begin
          data_q <= shift_d;
          go_q   <= !sent_base_d;
        end
      end

      case (state_q)
        IDLE, ERROR: begin
          if (bus.frame_start) begin
            state_q <= COLLECT;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        COLLECT: begin
          if (bus.frame_end || bus.frame_start) begin
            // frame_end wins over a simultaneous frame_start; a lone frame_start is an abort.
            if ((bus.frame_start && !bus.frame_end) || (idx_d != '0) || (cnt_d == '0)) begin
              err_q <= 1'b1;
            end
            if (sent_d) begin
              state_q  <= FINISH;
              finish_q <= 1'b1;
            end else begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
            end
          end
        end
        FINISH: begin
          state_q <= err_q ? ERROR : IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.go          = go_q;
  assign bus.finish      = finish_q;
  assign bus.word_count  = cnt_q;
  assign bus.frame_error = err_q;
  assign bus.busy        = busy_q;
endmodule
